// File: rtl/encode_index.sv
// Serializing index encoder: captures an 8-bit vector and streams the index of
// each set bit, lowest first, then reports popcount, parity and index XOR-fold.
module encode_index (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       busy,
  output logic [2:0] index_reg,
  output logic       index_reg_valid,
  output logic       done,
  output logic [3:0] popcount,
  output logic       parity,
  output logic [2:0] index_xor,
  output logic       result_valid
);

  localparam int unsigned VecW = 8;
  localparam int unsigned IdxW = 3;
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q;
  logic [VecW-1:0]   mask_q;
  logic [VecW-1:0]   mask_d;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   xor_q;
  logic [IdxW-1:0]   lsb_idx;

  logic              busy_q;
  logic [IdxW-1:0]   index_q;
  logic              valid_q;
  logic              done_q;
  logic [CntW-1:0]   popcount_q;
  logic              parity_q;
  logic [IdxW-1:0]   index_xor_q;
  logic              result_valid_q;

  // Priority encode the lowest set bit; mask_d drops that bit from the mask.
  always_comb begin
    lsb_idx = '0;
    for (int i = VecW - 1; i >= 0; i--) begin
      if (mask_q[i]) lsb_idx = IdxW'(i);
    end
    mask_d = mask_q & (mask_q - VecW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      cnt_q          <= '0;
      xor_q          <= '0;
      busy_q         <= 1'b0;
      index_q        <= '0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      popcount_q     <= '0;
      parity_q       <= 1'b0;
      index_xor_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q  <= data_in;
            cnt_q   <= '0;
            xor_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (mask_q != '0) begin
            index_q <= lsb_idx;
            valid_q <= 1'b1;
            mask_q  <= mask_d;
            cnt_q   <= cnt_q + CntW'(1);
            xor_q   <= xor_q ^ lsb_idx;
          end else begin
            // Mask exhausted: keep done high one more cycle for the decoder.
            valid_q <= 1'b0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          done_q         <= 1'b0;
          busy_q         <= 1'b0;
          popcount_q     <= cnt_q;
          parity_q       <= cnt_q[0];
          index_xor_q    <= xor_q;
          result_valid_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign index_reg       = index_q;
  assign index_reg_valid = valid_q;
  assign done            = done_q;
  assign popcount        = popcount_q;
  assign parity          = parity_q;
  assign index_xor       = index_xor_q;
  assign result_valid    = result_valid_q;

endmodule

// File: tb/tb_encode_index.sv
// Directed bench for encode_index: cycle-exact stream checks plus a one-hot
// XOR decoder model that rebuilds the vector from the emitted indices.
module tb_encode_index;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       start;
  logic       busy;
  logic [2:0] index_reg;
  logic       index_reg_valid;
  logic       done;
  logic [3:0] popcount;
  logic       parity;
  logic [2:0] index_xor;
  logic       result_valid;

  int checks = 0;
  int errors = 0;

  encode_index dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .start           (start),
    .busy            (busy),
    .index_reg       (index_reg),
    .index_reg_valid (index_reg_valid),
    .done            (done),
    .popcount        (popcount),
    .parity          (parity),
    .index_xor       (index_xor),
    .result_valid    (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},   32'(busy), 32'd0);
    chk({tag, ".index"},  32'(index_reg), 32'd0);
    chk({tag, ".valid"},  32'(index_reg_valid), 32'd0);
    chk({tag, ".done"},   32'(done), 32'd0);
    chk({tag, ".pop"},    32'(popcount), 32'd0);
    chk({tag, ".par"},    32'(parity), 32'd0);
    chk({tag, ".ixor"},   32'(index_xor), 32'd0);
    chk({tag, ".rv"},     32'(result_valid), 32'd0);
  endtask

  // Entered at a negedge with the DUT idle. Checks the full k+2 cycle frame.
  // With hold=1, start stays high and data_in moves to 0x03 during busy.
  task automatic frame(input string tag, input logic [7:0] d, input int k,
                       input logic [23:0] idx, input logic [2:0] exp_xor,
                       input logic exp_par, input logic hold);
    logic [7:0] dec;
    dec = 8'h00;
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    chk({tag, ".acc_busy"},  32'(busy), 32'd1);
    chk({tag, ".acc_done"},  32'(done), 32'd1);
    chk({tag, ".acc_valid"}, 32'(index_reg_valid), 32'd0);
    if (hold) begin
      data_in = 8'h03;
    end else begin
      start   = 1'b0;
      data_in = 8'h5A;
    end
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk({tag, ".valid"}, 32'(index_reg_valid), 32'd1);
      chk({tag, ".index"}, 32'(index_reg), 32'(idx[3*i +: 3]));
      chk({tag, ".done"},  32'(done), 32'd1);
      if (index_reg_valid) dec[index_reg] = ~dec[index_reg];
    end
    @(negedge clk);
    chk({tag, ".tail_valid"}, 32'(index_reg_valid), 32'd0);
    chk({tag, ".tail_done"},  32'(done), 32'd1);
    chk({tag, ".tail_busy"},  32'(busy), 32'd1);
    chk({tag, ".tail_rv"},    32'(result_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".end_done"}, 32'(done), 32'd0);
    chk({tag, ".end_busy"}, 32'(busy), 32'd0);
    chk({tag, ".rv"},       32'(result_valid), 32'd1);
    chk({tag, ".pop"},      32'(popcount), 32'(k));
    chk({tag, ".par"},      32'(parity), 32'(exp_par));
    chk({tag, ".ixor"},     32'(index_xor), 32'(exp_xor));
    chk({tag, ".dec_vec"},  32'(dec), 32'(d));
    chk({tag, ".dec_par"},  32'(^dec), 32'(exp_par));
    if (!hold) begin
      @(negedge clk);
      chk({tag, ".rv_pulse"}, 32'(result_valid), 32'd0);
      chk({tag, ".pop_hold"}, 32'(popcount), 32'(k));
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    frame("a5", 8'hA5, 4, 24'h000F50, 3'd0, 1'b0, 1'b0);
    frame("00", 8'h00, 0, 24'h000000, 3'd0, 1'b0, 1'b0);
    frame("ff", 8'hFF, 8, 24'hFAC688, 3'd0, 1'b0, 1'b0);

    // Held start: second frame is accepted right after the first completes.
    frame("80", 8'h80, 1, 24'h000007, 3'd7, 1'b1, 1'b1);
    frame("03", 8'h03, 2, 24'h000008, 3'd1, 1'b0, 1'b0);

    // Abort a frame after its second index.
    data_in = 8'hF0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("f0.idx0", 32'(index_reg), 32'd4);
    @(negedge clk);
    chk("f0.idx1", 32'(index_reg), 32'd5);
    chk("f0.val1", 32'(index_reg_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst.no_rv", 32'(result_valid), 32'd0);
      chk("midrst.idle",  32'(busy), 32'd0);
    end

    frame("01", 8'h01, 1, 24'h000000, 3'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
